// File: rtl/dp_ram_port_arbiter.sv
// dp_ram_port_arbiter
//   Round-robin arbiter that shares port A of a latency DP-RAM among NUM_REQ
//   requesters. One registered command per cycle goes to the RAM. Each read is
//   tagged so the returned word is steered to the requester that issued it.
//   Reads are held off while a write to the same address is still travelling
//   through the RAM's write pipeline.
//
// Ports
//   clka        clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_req       per-requester request, held until granted
//   i_we        per-requester 1=write, 0=read
//   i_addr      packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   i_din       packed write data, requester k at [k*WORD_W +: WORD_W]
//   o_gnt       one-hot grant (combinational); transfer when i_req[k] & o_gnt[k]
//   o_ram_en    RAM port A enable (registered)
//   o_ram_we    RAM port A write enable (registered)
//   o_ram_addr  RAM port A address (registered)
//   o_ram_din   RAM port A write data (registered)
//   i_ram_dout  RAM port A read data
//   o_rvalid    one-hot read-return strobe (registered)
//   o_rdata     read data, qualified by o_rvalid
module dp_ram_port_arbiter #(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned MEM_DEPTH  = 16,
  parameter  int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter  int unsigned RD_PIPE    = 2,
  parameter  int unsigned WR_PIPE    = 2,
  localparam int unsigned WORD_W     = DATA_WIDTH + $clog2(DATA_WIDTH) + 2
) (
  input  logic                          clka,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*WORD_W-1:0]     i_din,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_ram_en,
  output logic                          o_ram_we,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr,
  output logic [WORD_W-1:0]             o_ram_din,
  input  logic [WORD_W-1:0]             i_ram_dout,
  output logic [NUM_REQ-1:0]            o_rvalid,
  output logic [WORD_W-1:0]             o_rdata
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pointer: requester searched first in the current cycle
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_nxt;

  // Write tracker: addresses of writes not yet landed in the array
  logic [WR_PIPE-1:0]    wt_valid;
  logic [ADDR_WIDTH-1:0] wt_addr [WR_PIPE];

  // Read tags as one-hot requester vectors; all-zero means no read
  logic [NUM_REQ-1:0]    rd_issue;
  logic [NUM_REQ-1:0]    tag_q [RD_PIPE];

  logic [NUM_REQ-1:0]    hazard;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    hi_mask;
  logic [NUM_REQ-1:0]    elig_hi;
  logic [NUM_REQ-1:0]    pick_src;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic                  gnt_any;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WORD_W-1:0]     sel_din;

  // Read hazard: requester address matches any write still in flight
  always_comb begin
    hazard = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned s = 0; s < WR_PIPE; s++) begin
        if (wt_valid[s] && (wt_addr[s] == i_addr[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
          hazard[k] = 1'b1;
        end
      end
    end
  end

  // Writes are never blocked; reads are blocked by a pending same-address write
  assign eligible = i_req & ~(~i_we & hazard);

  // Requesters at or above the pointer get first pick
  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (i >= 32'(ptr));
    end
  end

  // Lowest set bit of the upper group, or of everyone when the upper group is empty
  assign elig_hi  = eligible & hi_mask;
  assign pick_src = (|elig_hi) ? elig_hi : eligible;
  assign gnt_oh   = pick_src & (~pick_src + NUM_REQ'(1));
  assign gnt_any  = |gnt_oh;
  assign o_gnt    = {NUM_REQ{i_rst_n}} & gnt_oh;

  // Pointer moves to the requester after the winner
  always_comb begin
    ptr_nxt = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // Command mux for the winning requester
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_oh[k]) begin
        sel_we   = i_we[k];
        sel_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din  = i_din[k*WORD_W +: WORD_W];
      end
    end
  end

  // RAM command register; address/data/we hold while idle
  always_ff @(posedge clka or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr        <= '0;
      o_ram_en   <= 1'b0;
      o_ram_we   <= 1'b0;
      o_ram_addr <= '0;
      o_ram_din  <= '0;
      rd_issue   <= '0;
    end else begin
      ptr      <= ptr_nxt;
      o_ram_en <= gnt_any;
      if (gnt_any) begin
        o_ram_we   <= sel_we;
        o_ram_addr <= sel_addr;
        o_ram_din  <= sel_din;
      end
      rd_issue <= (gnt_any && !sel_we) ? gnt_oh : '0;
    end
  end

  // Write tracker shift; loaded at the same edge the write is registered to the RAM
  always_ff @(posedge clka or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wt_valid <= '0;
      for (int unsigned s = 0; s < WR_PIPE; s++) begin
        wt_addr[s] <= '0;
      end
    end else begin
      wt_valid[0] <= gnt_any && sel_we;
      wt_addr[0]  <= sel_addr;
      for (int unsigned s = 1; s < WR_PIPE; s++) begin
        wt_valid[s] <= wt_valid[s-1];
        wt_addr[s]  <= wt_addr[s-1];
      end
    end
  end

  // Read tag shift; last stage lines up with valid RAM read data
  always_ff @(posedge clka or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned s = 0; s < RD_PIPE; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= rd_issue;
      for (int unsigned s = 1; s < RD_PIPE; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign o_rvalid = tag_q[RD_PIPE-1];
  assign o_rdata  = i_ram_dout;

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// tb_dp_ram_port_arbiter
//   Bench for dp_ram_port_arbiter with a latency RAM model attached to the
//   command port and a transaction-level reference model of grants, commands
//   and read returns.
module tb_dp_ram_port_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 4;
  localparam int W       = 13;
  localparam int RD_PIPE = 2;
  localparam int WR_PIPE = 2;

  logic              clka;
  logic              i_rst_n;
  logic [NREQ-1:0]   i_req;
  logic [NREQ-1:0]   i_we;
  logic [NREQ*AW-1:0] i_addr;
  logic [NREQ*W-1:0] i_din;
  logic [NREQ-1:0]   o_gnt;
  logic              o_ram_en;
  logic              o_ram_we;
  logic [AW-1:0]     o_ram_addr;
  logic [W-1:0]      o_ram_din;
  logic [W-1:0]      i_ram_dout;
  logic [NREQ-1:0]   o_rvalid;
  logic [W-1:0]      o_rdata;

  dp_ram_port_arbiter #(
    .NUM_REQ(NREQ), .DATA_WIDTH(8), .MEM_DEPTH(16), .ADDR_WIDTH(AW),
    .RD_PIPE(RD_PIPE), .WR_PIPE(WR_PIPE)
  ) dut (
    .clka(clka), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
    .i_addr(i_addr), .i_din(i_din), .o_gnt(o_gnt), .o_ram_en(o_ram_en),
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din),
    .i_ram_dout(i_ram_dout), .o_rvalid(o_rvalid), .o_rdata(o_rdata)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM port model: read data RD_PIPE cycles after the command, write lands WR_PIPE-1 edges later
  logic [W-1:0]  mem [16] = '{default: '0};
  logic [W-1:0]  dq [RD_PIPE] = '{default: '0};
  logic          wv = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [W-1:0]  wd = '0;

  always @(posedge clka) begin
    if (wv) mem[wa] <= wd;
    wv    <= o_ram_en & o_ram_we;
    wa    <= o_ram_addr;
    wd    <= o_ram_din;
    dq[0] <= mem[o_ram_addr];
    for (int i = 1; i < RD_PIPE; i++) dq[i] <= dq[i-1];
  end
  assign i_ram_dout = dq[RD_PIPE-1];

  // Reference model: pending writes block same-address reads, reads return
  // the value of the latest granted write at grant time
  typedef struct { int last_cyc; logic [AW-1:0] addr; } wr_t;
  typedef struct { int due; int id; logic [W-1:0] data; } rd_t;

  wr_t          wq[$];
  rd_t          rq[$];
  logic [W-1:0] shadow [16] = '{default: '0};
  int           m_ptr = 0;
  logic         e_en = 1'b0;
  logic         e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [W-1:0] e_din = '0;

  always @(negedge clka) begin : model
    int            g;
    int            k;
    logic          blk;
    logic [AW-1:0] a;
    logic [AW-1:0] ga;
    logic [W-1:0]  gd;
    logic [NREQ-1:0] ev;
    logic [W-1:0]  ed;
    if (!i_rst_n) begin
      chk("rst_gnt", 32'(o_gnt), 32'd0);
      chk("rst_ram_en", 32'(o_ram_en), 32'd0);
      chk("rst_ram_addr", 32'(o_ram_addr), 32'd0);
      chk("rst_rvalid", 32'(o_rvalid), 32'd0);
      m_ptr = 0;
      wq.delete();
      rq.delete();
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
    end else begin
      chk("ram_en", 32'(o_ram_en), 32'(e_en));
      chk("ram_we", 32'(o_ram_we), 32'(e_we));
      chk("ram_addr", 32'(o_ram_addr), 32'(e_addr));
      chk("ram_din", 32'(o_ram_din), 32'(e_din));
      ev = '0;
      ed = '0;
      if (rq.size() != 0 && rq[0].due == cyc) begin
        ev[rq[0].id] = 1'b1;
        ed = rq[0].data;
        rq.delete(0);
      end
      chk("rvalid", 32'(o_rvalid), 32'(ev));
      if (ev != '0) chk("rdata", 32'(o_rdata), 32'(ed));
      while (wq.size() != 0 && wq[0].last_cyc < cyc) wq.delete(0);
      g = -1;
      ga = '0;
      gd = '0;
      for (int j = 0; j < NREQ; j++) begin
        k = (m_ptr + j) % NREQ;
        a = i_addr[k*AW +: AW];
        blk = 1'b0;
        foreach (wq[q]) if (wq[q].addr == a) blk = 1'b1;
        if (g < 0 && i_req[k] && (i_we[k] || !blk)) begin
          g  = k;
          ga = a;
          gd = i_din[k*W +: W];
        end
      end
      chk("gnt", 32'(o_gnt), (g < 0) ? 32'd0 : 32'(1 << g));
      e_en = (g >= 0);
      if (g >= 0) begin
        e_we   = i_we[g];
        e_addr = ga;
        e_din  = gd;
        m_ptr  = (g + 1) % NREQ;
        if (i_we[g]) begin
          shadow[ga] = gd;
          wq.push_back('{last_cyc: cyc + WR_PIPE, addr: ga});
        end else begin
          rq.push_back('{due: cyc + 1 + RD_PIPE, id: g, data: shadow[ga]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic set_req(input int k, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
    i_req[k] = r;
    i_we[k]  = w;
    i_addr[k*AW +: AW] = a;
    i_din[k*W +: W]    = d;
  endtask

  typedef struct { logic [NREQ-1:0] req; logic [NREQ-1:0] gnt; } vec_t;
  vec_t tv [17];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int waited;
    int lat;
    int rv_seen;
    logic [NREQ-1:0] seen;

    tv = '{'{4'hF, 4'h1}, '{4'hF, 4'h2}, '{4'hF, 4'h4}, '{4'hF, 4'h8},
           '{4'hF, 4'h1}, '{4'hF, 4'h2}, '{4'hF, 4'h4}, '{4'h9, 4'h8},
           '{4'h9, 4'h1}, '{4'h6, 4'h2}, '{4'h6, 4'h4}, '{4'h0, 4'h0},
           '{4'h6, 4'h2}, '{4'hA, 4'h8}, '{4'hA, 4'h2}, '{4'h1, 4'h1},
           '{4'h0, 4'h0}};

    i_rst_n = 1'b0;
    i_req = '0; i_we = '0; i_addr = '0; i_din = '0;

    // Reset with every requester asking
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 1'b0, AW'(8 + k), '0);
    repeat (3) begin
      @(negedge clka);
      chk("t1_gnt", 32'(o_gnt), 32'd0);
      chk("t1_ram_en", 32'(o_ram_en), 32'd0);
      chk("t1_rvalid", 32'(o_rvalid), 32'd0);
    end
    tick();
    i_rst_n = 1'b1;
    i_req = '0;

    // Round-robin order and pointer wrap, all reads to distinct addresses
    foreach (tv[i]) begin
      i_req = tv[i].req;
      @(negedge clka);
      chk("tbl_gnt", 32'(o_gnt), 32'(tv[i].gnt));
      tick();
    end
    i_req = '0;
    repeat (6) tick();

    // Write then same-address read: read held for WR_PIPE cycles
    set_req(0, 1'b1, 1'b1, 4'd3, 13'h1A5);
    @(negedge clka);
    chk("t3_wr_gnt", 32'(o_gnt), 32'h1);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, '0);
    set_req(1, 1'b1, 1'b0, 4'd3, '0);
    waited = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clka);
      if (o_gnt[1]) break;
      waited++;
      tick();
    end
    chk("t3_block_cycles", 32'(waited), 32'(WR_PIPE));
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      i_req[1] = 1'b0;
      @(negedge clka);
      lat++;
      if (o_rvalid != '0) break;
    end
    chk("t3_rd_latency", 32'(lat), 32'(RD_PIPE + 1));
    chk("t3_rvalid", 32'(o_rvalid), 32'h2);
    chk("t3_rdata", 32'(o_rdata), 32'h1A5);
    tick();
    repeat (4) tick();

    // Blocked read must not stall an unrelated read
    set_req(0, 1'b1, 1'b1, 4'd3, 13'h0F0);
    @(negedge clka);
    chk("t4_wr_gnt", 32'(o_gnt), 32'h1);
    tick();
    set_req(0, 1'b0, 1'b0, 4'd0, '0);
    set_req(1, 1'b1, 1'b0, 4'd3, '0);
    set_req(2, 1'b1, 1'b0, 4'd7, '0);
    @(negedge clka);
    chk("t4_bypass_gnt", 32'(o_gnt), 32'h4);
    tick();
    i_req[2] = 1'b0;
    waited = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clka);
      if (o_gnt[1]) begin
        waited = 1;
        break;
      end
      tick();
    end
    chk("t4_blocked_read_gnt", 32'(waited), 32'd1);
    tick();
    i_req = '0;
    repeat (6) tick();

    // Reset one cycle after a read is issued: its return is dropped
    set_req(0, 1'b1, 1'b0, 4'd3, '0);
    @(negedge clka);
    chk("t6_rd_gnt", 32'(o_gnt), 32'h1);
    tick();
    i_req = '0;
    tick();
    i_rst_n = 1'b0;
    rv_seen = 0;
    repeat (2) begin
      @(negedge clka);
      if (o_rvalid != '0) rv_seen++;
      tick();
    end
    i_rst_n = 1'b1;
    repeat (5) begin
      @(negedge clka);
      if (o_rvalid != '0) rv_seen++;
      tick();
    end
    chk("t6_dropped_rvalid", 32'(rv_seen), 32'd0);
    set_req(0, 1'b1, 1'b0, 4'd3, '0);
    @(negedge clka);
    chk("t6_next_gnt", 32'(o_gnt), 32'h1);
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      i_req[0] = 1'b0;
      @(negedge clka);
      lat++;
      if (o_rvalid != '0) break;
    end
    chk("t6_rvalid", 32'(o_rvalid), 32'h1);
    chk("t6_rdata", 32'(o_rdata), 32'h0F0);
    tick();
    repeat (4) tick();

    // Random traffic on a small address range to provoke hazards
    for (int c = 0; c < 800; c++) begin
      @(negedge clka);
      seen = o_gnt;
      tick();
      for (int k = 0; k < NREQ; k++) begin
        if (!i_req[k] || seen[k]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(k, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)), W'($urandom));
          else
            i_req[k] = 1'b0;
        end
      end
    end
    i_req = '0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
